// File: rtl/fir_pkg.sv
// fir_pkg: register map, ap_ctrl bit positions and sequencer states shared by the fir control slice
package fir_pkg;
  localparam int ADDR_AP_CTRL  = 'h00;
  localparam int ADDR_LEN      = 'h10;
  localparam int ADDR_TAP_BASE = 'h20;
  localparam int AP_START_BIT  = 0;
  localparam int AP_DONE_BIT   = 1;
  localparam int AP_IDLE_BIT   = 2;
  typedef enum logic {S_IDLE, S_RUN} fir_state_e;
endpackage

// File: rtl/fir_axil_if.sv
// fir_axil_if: AXI-lite AW/W/AR/R handshake timing with write address/data and read address capture
// ports: axis_clk/axis_rst_n clock and sync active-low reset; AW/W/AR/R host channel signals;
//        ar_hold delays a read acceptance by one cycle; wr_take flags that awready/wready rise next cycle;
//        wr_addr/wr_data/rd_addr hold the captured request during its ready cycle
module fir_axil_if
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  input  logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rready,
  input  logic                   ar_hold,
  output logic                   awready,
  output logic                   wready,
  output logic                   arready,
  output logic                   rvalid,
  output logic                   wr_take,
  output logic [pADDR_WIDTH-1:0] wr_addr,
  output logic [pDATA_WIDTH-1:0] wr_data,
  output logic [pADDR_WIDTH-1:0] rd_addr
);
  logic awready_q, awready_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [pADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [pDATA_WIDTH-1:0] wr_data_q, wr_data_d;
  always_comb begin
    awready_d = awvalid && wvalid && !awready_q;
    arready_d = arvalid && !rvalid_q && !arready_q && !ar_hold;
    rvalid_d  = arready_q || (rvalid_q && !rready);
    wr_addr_d = awready_d ? awaddr : wr_addr_q;
    wr_data_d = awready_d ? wdata : wr_data_q;
    rd_addr_d = arready_d ? araddr : rd_addr_q;
  end
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      awready_q <= awready_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end
  assign awready = awready_q;
  assign wready  = awready_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign wr_take = awready_d;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_addr = rd_addr_q;
endmodule

// File: rtl/fir_ctrl.sv
// fir_ctrl: AXI-lite register decode, ap_start/ap_done/ap_idle sequencer and tap-RAM port arbiter for the fir engine
// ports: axis_clk/axis_rst_n clock and sync active-low reset; AXI-lite AW/W/AR/R host channels (no B);
//        tap_* single tap-RAM port (tap_Do has 1-cycle latency); eng_tap_EN/eng_tap_A engine tap reads;
//        ap_start_o launch pulse, data_length_o sample count, eng_done completion pulse from the engine
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic                   eng_tap_EN,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  output logic                   ap_start_o,
  output logic [pDATA_WIDTH-1:0] data_length_o,
  input  logic                   eng_done
);
  localparam logic [pADDR_WIDTH-1:0] A_CTRL = pADDR_WIDTH'(ADDR_AP_CTRL);
  localparam logic [pADDR_WIDTH-1:0] A_LEN  = pADDR_WIDTH'(ADDR_LEN);
  localparam logic [pADDR_WIDTH-1:0] TAP_LO = pADDR_WIDTH'(ADDR_TAP_BASE);
  localparam logic [pADDR_WIDTH-1:0] TAP_HI = pADDR_WIDTH'(ADDR_TAP_BASE + 4 * Tape_Num);

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return a >= TAP_LO && a < TAP_HI && a[1:0] == 2'b00;
  endfunction

  logic wr_take, ar_hold;
  logic [pADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [pDATA_WIDTH-1:0] wr_data;

  fir_axil_if #(
    .pADDR_WIDTH(pADDR_WIDTH),
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_axil (
    .axis_clk  (axis_clk),
    .axis_rst_n(axis_rst_n),
    .awvalid   (awvalid),
    .awaddr    (awaddr),
    .wvalid    (wvalid),
    .wdata     (wdata),
    .arvalid   (arvalid),
    .araddr    (araddr),
    .rready    (rready),
    .ar_hold   (ar_hold),
    .awready   (awready),
    .wready    (wready),
    .arready   (arready),
    .rvalid    (rvalid),
    .wr_take   (wr_take),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr)
  );

  fir_state_e state_q, state_d;
  logic ap_done_q, ap_done_d, start_q, start_d, rtap_q, rtap_d, rctrl_q, rctrl_d;
  logic [pDATA_WIDTH-1:0] len_q, len_d, rdata_q, rdata_d, ctrl_val, reg_val;
  logic idle, start, wr_len, wr_tap, rd_tap, done_evt;

  // Deciding from the live addresses (not the FSM state) keeps the two tap accesses apart even
  // if the engine finishes between the accept decision and the ready cycle.
  assign ar_hold = wr_take && is_tap(awaddr) && is_tap(araddr);

  always_comb begin
    idle     = state_q == S_IDLE;
    done_evt = !idle && eng_done;
    start    = awready && wr_addr == A_CTRL && wr_data[AP_START_BIT] && idle;
    wr_len   = awready && wr_addr == A_LEN && idle;
    wr_tap   = awready && is_tap(wr_addr) && idle;
    rd_tap   = arready && is_tap(rd_addr) && idle;
    ctrl_val = '0;
    ctrl_val[AP_DONE_BIT] = ap_done_q;
    ctrl_val[AP_IDLE_BIT] = idle;
    reg_val  = rd_addr == A_CTRL ? ctrl_val :
               rd_addr == A_LEN ? len_q :
               (is_tap(rd_addr) && !idle) ? '1 : '0;
    state_d   = start ? S_RUN : done_evt ? S_IDLE : state_q;
    ap_done_d = done_evt || (ap_done_q && !start && !(rvalid && rready && rctrl_q));
    start_d   = start;
    len_d     = wr_len ? wr_data : len_q;
    rtap_d    = rd_tap;
    rctrl_d   = arready ? rd_addr == A_CTRL : rctrl_q;
    // tap_Do is only valid in the first rvalid cycle; latch it so rdata holds until rready
    rdata_d   = arready ? reg_val : rtap_q ? tap_Do : rdata_q;
    tap_EN    = idle ? (wr_tap || rd_tap) : eng_tap_EN;
    tap_WE    = wr_tap ? 4'hF : 4'h0;
    tap_A     = !idle ? eng_tap_A : (wr_tap ? wr_addr : rd_addr) - TAP_LO;
    tap_Di    = wr_data;
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_q   <= S_IDLE;
      ap_done_q <= 1'b0;
      start_q   <= 1'b0;
      len_q     <= '0;
      rtap_q    <= 1'b0;
      rctrl_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ap_done_q <= ap_done_d;
      start_q   <= start_d;
      len_q     <= len_d;
      rtap_q    <= rtap_d;
      rctrl_q   <= rctrl_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata         = rtap_q ? tap_Do : rdata_q;
  assign ap_start_o    = start_q;
  assign data_length_o = len_q;
endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: directed and randomized checks of fir_ctrl against a register-level reference model
module tb_fir_ctrl;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NT = 11;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n = 1'b0;
  logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic          awready, wready, arready, rvalid;
  logic [AW-1:0] awaddr = '0, araddr = '0, tap_A, eng_tap_A = '0;
  logic [DW-1:0] wdata = '0, rdata, tap_Di, tap_Do, data_length_o;
  logic [3:0]    tap_WE;
  logic          tap_EN, eng_tap_EN = 1'b0, ap_start_o, eng_done = 1'b0;

  always #5 axis_clk = ~axis_clk;

  fir_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .eng_tap_EN(eng_tap_EN), .eng_tap_A(eng_tap_A),
    .ap_start_o(ap_start_o), .data_length_o(data_length_o), .eng_done(eng_done)
  );

  // tap BRAM: byte write enables, registered read data
  logic [DW-1:0] ram [0:15];
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      for (int b = 0; b < 4; b++) if (tap_WE[b]) ram[tap_A[5:2]][8*b +: 8] <= tap_Di[8*b +: 8];
      tap_Do <= ram[tap_A[5:2]];
    end
  end

  // reference model: register contents and sequencer status
  logic [DW-1:0] m_tap [NT];
  logic [DW-1:0] m_len;
  bit m_run, m_done;
  int checks = 0, errors = 0;

  function automatic bit m_is_tap(input int a);
    return a >= 32 && a < 32 + 4 * NT && a % 4 == 0;
  endfunction

  function automatic logic [DW-1:0] m_read(input int a);
    if (a == 0) return {29'b0, !m_run, m_done, 1'b0};
    if (a == 16) return m_len;
    if (m_is_tap(a)) return m_run ? 32'hFFFF_FFFF : m_tap[(a - 32) / 4];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge axis_clk);
    #1;
  endtask

  task automatic axi_write(input int a, input logic [DW-1:0] d);
    int n;
    bit tap, st;
    tap = m_is_tap(a) && !m_run;
    st  = a == 0 && d[0] && !m_run;
    awaddr = AW'(a); wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!awready && n < 8);
    chk("aw_handshake", 32'(awready), 32'd1);
    chk("w_with_aw", 32'(wready), 32'd1);
    chk("wr_tap_we", 32'(tap_WE), tap ? 32'hF : 32'h0);
    if (tap) chk("wr_tap_a", 32'(tap_A), 32'(a - 32));
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    if (a == 16 && !m_run) m_len = d;
    if (tap) m_tap[(a - 32) / 4] = d;
    if (st) begin m_run = 1'b1; m_done = 1'b0; end
    chk("ap_start_pulse", 32'(ap_start_o), 32'(st));
    chk("awready_drop", 32'(awready), 32'd0);
  endtask

  task automatic axi_read(input int a, input string tag);
    int n, w;
    logic [DW-1:0] exp;
    exp = m_read(a);
    araddr = AW'(a); arvalid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!arready && n < 8);
    chk("ar_handshake", 32'(arready), 32'd1);
    if (m_is_tap(a) && !m_run) begin
      chk("rd_tap_en", 32'(tap_EN), 32'd1);
      chk("rd_tap_a", 32'(tap_A), 32'(a - 32));
    end
    tick();
    arvalid = 1'b0;
    chk("rvalid_latency", 32'(rvalid), 32'd1);
    chk(tag, rdata, exp);
    w = int'($urandom_range(0, 2));
    repeat (w) begin
      tick();
      chk("rvalid_hold", 32'(rvalid), 32'd1);
      chk("rdata_hold", rdata, exp);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rvalid_drop", 32'(rvalid), 32'd0);
    if (a == 0) m_done = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v, keep24;
    int k, a;
    m_run = 1'b0; m_done = 1'b0; m_len = '0;
    foreach (m_tap[i]) m_tap[i] = '0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; awaddr = 12'h010; wdata = 32'h5;
    repeat (3) begin
      tick();
      chk("rst_awready", 32'(awready), 32'd0);
      chk("rst_arready", 32'(arready), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
    end
    chk("rst_tap_en", 32'(tap_EN), 32'd0);
    chk("rst_tap_we", 32'(tap_WE), 32'd0);
    chk("rst_ap_start", 32'(ap_start_o), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_len", data_length_o, 32'd0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    axis_rst_n = 1'b1;
    tick();

    axi_read(0, "ctrl_after_reset");
    chk("len_after_reset", data_length_o, 32'd0);
    axi_write(16, 32'h30);
    axi_read(16, "len_readback");
    chk("len_out", data_length_o, m_len);

    for (int i = 0; i < NT; i++) axi_write(32 + 4 * i, 32'(i + 1));
    for (int i = 0; i < NT; i++) axi_read(32 + 4 * i, "tap_readback");

    axi_write('h4C, $urandom);
    axi_write('h22, $urandom);
    axi_read('h14, "unmapped_14");
    axi_read('h4C, "unmapped_4c");
    axi_read('h22, "unaligned_22");
    axi_read('h48, "last_tap");

    keep24 = m_tap[1];
    axi_write(0, 32'h1);
    tick();
    chk("ap_start_one_cycle", 32'(ap_start_o), 32'd0);
    axi_read(0, "ctrl_running");
    axi_write('h24, 32'hDEAD);
    axi_write(16, $urandom);
    chk("len_locked_in_run", data_length_o, m_len);
    axi_write(0, 32'h1);
    repeat (4) begin
      eng_tap_EN = 1'($urandom_range(0, 1));
      eng_tap_A  = AW'(4 * $urandom_range(0, NT - 1));
      #1;
      chk("eng_tap_en", 32'(tap_EN), 32'(eng_tap_EN));
      chk("eng_tap_a", 32'(tap_A), 32'(eng_tap_A));
      chk("eng_tap_we", 32'(tap_WE), 32'd0);
      tick();
    end
    eng_tap_EN = 1'b0;
    axi_read('h24, "tap_read_in_run");
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    m_run = 1'b0; m_done = 1'b1;
    axi_read(0, "ctrl_done");
    axi_read(0, "ctrl_done_cleared");
    axi_read('h24, "tap_after_run");
    chk("tap24_preserved", m_read('h24), keep24);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    axi_read(0, "ctrl_done_in_idle");

    v = $urandom;
    awaddr = 12'h020; wdata = v; araddr = 12'h028;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    chk("col_awready", 32'(awready), 32'd1);
    chk("col_ar_deferred", 32'(arready), 32'd0);
    chk("col_we", 32'(tap_WE), 32'hF);
    chk("col_wr_a", 32'(tap_A), 32'd0);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    m_tap[0] = v;
    chk("col_arready", 32'(arready), 32'd1);
    chk("col_awready_done", 32'(awready), 32'd0);
    chk("col_rd_a", 32'(tap_A), 32'd8);
    tick();
    arvalid = 1'b0;
    chk("col_rvalid", 32'(rvalid), 32'd1);
    chk("col_rdata", rdata, m_tap[2]);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    axi_read('h20, "col_written_tap");

    repeat (40) begin
      k = int'($urandom_range(0, NT + 2));
      a = k < NT ? 32 + 4 * k : k == NT ? 16 : k == NT + 1 ? 'h50 : 'h0C;
      if ($urandom_range(0, 2) < 2) axi_write(a, $urandom);
      else axi_read(a, "rand_read");
      chk("rand_len_out", data_length_o, m_len);
    end
    for (int i = 0; i < NT; i++) axi_read(32 + 4 * i, "final_tap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_ctrl.md
Name: fir_ctrl

Overview:
- AXI-lite register front-end and sequencer for the fir datapath.
- Decodes configuration writes and reads: ap_ctrl, data_length, and tap coefficients.
- Owns and arbitrates the single tap-RAM port between the AXI-lite host and the FIR engine.
- Runs the ap_start/ap_done/ap_idle state machine that launches the engine and reports completion.

Parameters:
- pADDR_WIDTH, 12, AXI-lite and BRAM address width.
- pDATA_WIDTH, 32, data width.
- Tape_Num, 11, number of tap coefficients.

Ports:
- axis_clk  in  1  single clock.
- axis_rst_n  in  1  reset, synchronous, active-low.
- awvalid/awready  in/out  1/1  write-address handshake.
- awaddr  in  pADDR_WIDTH  write byte address.
- wvalid/wready  in/out  1/1  write-data handshake.
- wdata  in  pDATA_WIDTH  write data.
- arvalid/arready  in/out  1/1  read-address handshake.
- araddr  in  pADDR_WIDTH  read byte address.
- rvalid  out  1  read data valid.
- rready  in  1  read data accepted.
- rdata  out  pDATA_WIDTH  read data.
- tap_WE  out  4  tap RAM byte write enables.
- tap_EN  out  1  tap RAM enable.
- tap_Di  out  pDATA_WIDTH  tap RAM write data.
- tap_A  out  pADDR_WIDTH  tap RAM byte address.
- tap_Do  in  pDATA_WIDTH  tap RAM read data; 1-cycle latency.
- eng_tap_EN  in  1  engine tap-read request.
- eng_tap_A  in  pADDR_WIDTH  engine tap byte address.
- ap_start_o  out  1  one-cycle launch pulse to the engine.
- data_length_o  out  pDATA_WIDTH  sample count for the engine.
- eng_done  in  1  pulse from the engine on the final sm_tlast handshake.

Behaviour:
- Register map:
  - 0x00 ap_ctrl: bit0 ap_start (write-1), bit1 ap_done, bit2 ap_idle.
  - 0x10 data_length.
  - 0x20+4*i tap[i], i = 0..Tape_Num-1.
  - Any other address: write ignored, read returns 0.
- Reset (sync, axis_rst_n=0 at a rising edge):
  - awready, wready, arready, rvalid, tap_EN, ap_start_o = 0; tap_WE=0; rdata=0; data_length_o=0.
  - FSM enters IDLE; ap_done=0, ap_idle=1.
  - Any in-flight transaction is dropped.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on an accepted write to 0x00 with wdata[0]=1. ap_start_o=1 for exactly the cycle after the handshake; ap_done clears; ap_idle=0.
  - RUN -> IDLE on eng_done. Same edge sets ap_done=1, ap_idle=1.
  - ap_start reads 0 in all states.
  - A read of 0x00 clears ap_done on the rvalid&rready cycle.
  - eng_done in IDLE is ignored.
- Write channel:
  - When awvalid&wvalid are both seen high and no write is pending, awready and wready assert together for one cycle in the next cycle.
  - The register write is performed at the end of that cycle.
  - There is no B channel.
  - A tap write drives tap_EN=1, tap_WE=4'hF, tap_A=awaddr-0x20, tap_Di=wdata during the ready cycle.
- Read channel:
  - arready pulses one cycle after arvalid is seen, only when rvalid=0.
  - For a tap read, tap_EN=1 and tap_A=araddr-0x20 in the arready cycle; rvalid asserts next cycle with rdata=tap_Do.
  - Register reads use the same 1-cycle rvalid latency.
  - rvalid and rdata hold until rready.
- Tap-port arbitration:
  - In RUN, the engine owns the port: tap_EN=eng_tap_EN, tap_A=eng_tap_A, tap_WE=0.
  - Host tap/data_length writes in RUN are accepted (handshake completes) but have no effect.
  - Host tap reads in RUN return 0xFFFF_FFFF.
  - In IDLE, a write and a read needing the port in the same cycle: the write wins; arready is deferred one cycle.
- Writes to 0x00 with bit0=1 while in RUN are ignored.

Decomposition:
- Package fir_pkg: register offsets (ADDR_AP_CTRL=0x00, ADDR_LEN=0x10, ADDR_TAP_BASE=0x20), ap_ctrl bit indices, FSM state enum.
- One sub-module, fir_axil_if: AW/W/AR/R handshake timing and address capture. fir_ctrl holds the decode, FSM and tap mux.

Test Plan:
- Reset with awvalid held high -> awready=0 during reset; read of 0x00 after reset returns 0x4; data_length_o=0.
- Write 0x10=0x30, then read 0x10 -> rdata=0x30 one cycle after arready; data_length_o=0x30.
- Write taps 0x20..0x48 with values 1..11, then read back -> each returns its value; tap_WE=4'hF on each write cycle.
- Write 0x00=0x1 -> ap_start_o pulses 1 cycle; read 0x00 = 0x0. Pulse eng_done -> read 0x00 = 0x6, next read 0x00 = 0x4.
- In RUN: write 0x24=0xDEAD -> no tap_WE; eng_tap_A passes to tap_A; read 0x24 returns 0xFFFF_FFFF. After done, read 0x24 returns the original value.
- Same-cycle write 0x20 and read 0x28 in IDLE -> the write completes first; arready is one cycle later; the read returns the correct tap.
